mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data-memory port (`mem_control`) between two requesters.
- M0 is the CPU load/store path. M1 is the debug/program loader fed from the USB FIFO interface.
- Round-robin arbitration, with an optional bounded lock that lets M1 issue back-to-back transfers.
- One transaction outstanding at a time. Request fields are latched on grant, so requesters are released after a single grant pulse.

Parameters:
- BURST_MAX, 4: maximum consecutive M1 transactions granted while m1_lock_i is held (range 1..15).
- ADDR_W, 32: address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- mN_req_i  in  1  requester N (N=0,1) has a valid request.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_acc_i  in  2  access size; MEM_ACC_* encoding from const.v.
- mN_addr_i  in  ADDR_W  byte address.
- mN_wdata_i  in  32  write data.
- mN_gnt_o  out  1  one-cycle pulse: request latched; requester may change its inputs next cycle.
- mN_rvalid_o  out  1  one-cycle pulse: read data for N is valid.
- mN_rdata_o  out  32  read data; holds its value until the next read response to N.
- m1_lock_i  in  1  M1 requests back-to-back ownership.
- mem_req_o  out  1  request to memory.
- mem_we_o  out  1  latched write enable.
- mem_acc_o  out  2  latched access size.
- mem_addr_o  out  ADDR_W  latched address.
- mem_wdata_o  out  32  latched write data.
- mem_gnt_i  in  1  memory accepted mem_req_o this cycle.
- mem_rvalid_i  in  1  read response valid.
- mem_rdata_i  in  32  read response data.
- busy_o  out  1  state != ST_IDLE.

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values:
  - All outputs 0, including the rdata registers.
  - state = ST_IDLE, last_owner = 1 (so M0 wins the first tie), burst_cnt = 0.
- FSM states: ST_IDLE, ST_ISSUE, ST_WAIT_RD. All outputs are registered or decoded from state plus latched fields. There are no combinational paths from inputs to outputs.
- ST_IDLE:
  - With no mN_req_i asserted, stay in ST_IDLE.
  - Otherwise choose an owner:
    - Lock rule first: if last_owner = 1, m1_lock_i = 1, m1_req_i = 1 and burst_cnt < BURST_MAX-1, the owner is M1 and burst_cnt increments.
    - Otherwise, if only one requester is active, it is the owner.
    - If both are active, the owner is the one that is not last_owner.
    - burst_cnt clears whenever the owner is M0 or m1_lock_i = 0.
  - At the clock edge, latch the owner's we/acc/addr/wdata, set owner and last_owner, and go to ST_ISSUE.
- ST_ISSUE:
  - First cycle in this state: mOwner_gnt_o = 1.
  - mem_req_o = 1, with latched fields stable, until mem_gnt_i = 1.
  - On mem_gnt_i: a write returns to ST_IDLE; a read goes to ST_WAIT_RD.
- ST_WAIT_RD:
  - mem_req_o = 0.
  - On mem_rvalid_i: register mem_rdata_i into mOwner_rdata_o, pulse mOwner_rvalid_o on the next cycle, and go to ST_IDLE.
- Latency (request sampled in cycle t):
  - gnt and mem_req_o high in cycle t+1.
  - With mem_gnt_i immediate, a write completes in 2 cycles.
  - A read takes 2 + memory latency + 1 cycles to reach rvalid.
- Fairness: M0 waits at most BURST_MAX M1 transactions plus the one in flight.
- Boundary conditions:
  - mem_gnt_i outside ST_ISSUE and mem_rvalid_i outside ST_WAIT_RD are ignored.
  - mN_req_i deasserted while in ST_ISSUE or ST_WAIT_RD has no effect; the transfer was already latched.
  - A request held high after its gnt is treated as a new request in the next ST_IDLE.
  - rst_i mid-transaction: return to the reset state. A memory response arriving after reset is dropped.
  - BURST_MAX = 1 disables the lock (pure round-robin).

Decomposition:
- Add to const.v: `ARB_ST_IDLE/ISSUE/WAIT_RD` (2-bit) and `ARB_OWNER_M0/M1`.
- Reuse the existing MEM_ACC_* encodings.
- No sub-module: the two-way round-robin/lock pick is a local function inside mem_arbiter.

Test Plan:
- Reset, then M0 read 0x100 with memory returning 0xDEADBEEF 2 cycles after mem_gnt_i.
  -> m0_gnt_o at t+1; mem_addr_o = 0x100 with mem_we_o = 0; m0_rvalid_o pulse with m0_rdata_o = 0xDEADBEEF; M1 outputs stay 0.
- M0 and M1 write requests held continuously, mem_gnt_i tied 1, lock = 0.
  -> grants alternate M0, M1, M0, M1, one every 2 cycles; mem_wdata_o matches each owner.
- M1 lock = 1, BURST_MAX = 4, both requesting writes continuously.
  -> M0 wins the tie first, then M1 gets 4 consecutive grants, then M0 is granted; the pattern repeats.
- mem_gnt_i held 0 for 5 cycles in ST_ISSUE while the M0 inputs change.
  -> mem_addr_o/wdata_o stay at the latched values; m0_gnt_o pulses exactly once.
- rst_i asserted while in ST_WAIT_RD, then mem_rvalid_i = 1 one cycle after release.
  -> no rvalid pulse on either requester; busy_o = 0; the next M1 request is granted normally.
- Stray mem_rvalid_i in ST_IDLE with data 0x55.
  -> ignored; m0_rdata_o/m1_rdata_o unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master data-memory arbiter.
// Access sizes match the memory port's existing byte/half/word codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ST_IDLE    = 2'd0,
        ARB_ST_ISSUE   = 2'd1,
        ARB_ST_WAIT_RD = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_M0 = 1'b0,
        ARB_OWNER_M1 = 1'b1
    } arb_owner_e;

    localparam logic [1:0] MEM_ACC_BYTE = 2'd0;
    localparam logic [1:0] MEM_ACC_HALF = 2'd1;
    localparam logic [1:0] MEM_ACC_WORD = 2'd2;

    typedef struct packed {
        arb_owner_e owner;
        logic       lock_hit;
    } arb_pick_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between CPU (M0)
// and debug loader (M1), with a bounded back-to-back lock for M1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [1:0]        m0_acc_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [1:0]        m1_acc_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    input  logic              m1_lock_i,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_acc_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,

    output logic              busy_o
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX - 1);

    arb_state_e state_q;
    arb_owner_e owner_q;
    arb_owner_e last_owner_q;
    logic [3:0] burst_cnt_q;
    arb_pick_t  sel;

    // Lock keeps M1 only while it already owns the port and budget remains
    function automatic arb_pick_t pick(
        input logic       r0,
        input logic       r1,
        input logic       lock,
        input arb_owner_e last,
        input logic [3:0] cnt
    );
        arb_pick_t p;
        p.lock_hit = (last == ARB_OWNER_M1) && lock && r1
                     && (cnt < BURST_LIM);
        if (p.lock_hit)
            p.owner = ARB_OWNER_M1;
        else if (r0 && !r1)
            p.owner = ARB_OWNER_M0;
        else if (!r0 && r1)
            p.owner = ARB_OWNER_M1;
        else if (last == ARB_OWNER_M0)
            p.owner = ARB_OWNER_M1;
        else
            p.owner = ARB_OWNER_M0;
        return p;
    endfunction

    always_comb begin
        sel = pick(m0_req_i, m1_req_i, m1_lock_i,
                   last_owner_q, burst_cnt_q);
    end

    assign busy_o = (state_q != ARB_ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_ST_IDLE;
            owner_q      <= ARB_OWNER_M0;
            last_owner_q <= ARB_OWNER_M1;
            burst_cnt_q  <= '0;
            m0_gnt_o     <= 1'b0;
            m1_gnt_o     <= 1'b0;
            m0_rvalid_o  <= 1'b0;
            m1_rvalid_o  <= 1'b0;
            m0_rdata_o   <= '0;
            m1_rdata_o   <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_acc_o    <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            m0_gnt_o    <= 1'b0;
            m1_gnt_o    <= 1'b0;
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            unique case (state_q)
                ARB_ST_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        owner_q      <= sel.owner;
                        last_owner_q <= sel.owner;
                        if (sel.lock_hit)
                            burst_cnt_q <= burst_cnt_q + 4'd1;
                        else if (sel.owner == ARB_OWNER_M0 || !m1_lock_i)
                            burst_cnt_q <= '0;
                        if (sel.owner == ARB_OWNER_M1) begin
                            mem_we_o    <= m1_we_i;
                            mem_acc_o   <= m1_acc_i;
                            mem_addr_o  <= m1_addr_i;
                            mem_wdata_o <= m1_wdata_i;
                            m1_gnt_o    <= 1'b1;
                        end else begin
                            mem_we_o    <= m0_we_i;
                            mem_acc_o   <= m0_acc_i;
                            mem_addr_o  <= m0_addr_i;
                            mem_wdata_o <= m0_wdata_i;
                            m0_gnt_o    <= 1'b1;
                        end
                        mem_req_o <= 1'b1;
                        state_q   <= ARB_ST_ISSUE;
                    end
                end
                ARB_ST_ISSUE: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= mem_we_o ? ARB_ST_IDLE
                                              : ARB_ST_WAIT_RD;
                    end
                end
                ARB_ST_WAIT_RD: begin
                    if (mem_rvalid_i) begin
                        if (owner_q == ARB_OWNER_M1) begin
                            m1_rdata_o  <= mem_rdata_i;
                            m1_rvalid_o <= 1'b1;
                        end else begin
                            m0_rdata_o  <= mem_rdata_i;
                            m0_rvalid_o <= 1'b1;
                        end
                        state_q <= ARB_ST_IDLE;
                    end
                end
                default: state_q <= ARB_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a grant/read-response scoreboard.
// Expected transfers are queued at drive time and popped by a monitor.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [1:0]  m0_acc_i, m1_acc_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
    logic [1:0]  mem_acc_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.BURST_MAX(4), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_acc_i(m0_acc_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_acc_i(m1_acc_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_lock_i(m1_lock_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_acc_o(mem_acc_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    typedef struct {
        logic        owner;
        logic        we;
        logic [1:0]  acc;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_gnt(input logic o, input logic we,
                           input logic [1:0] acc, input logic [31:0] a,
                           input logic [31:0] d);
        gnt_t g;
        g.owner = o; g.we = we; g.acc = acc; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic exp_rd(input logic o, input logic [31:0] d);
        rd_t r;
        r.owner = o; r.data = d;
        rq.push_back(r);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Scoreboard monitor: every grant and read response must be expected
    always @(negedge clk_i) begin
        gnt_t g;
        rd_t  r;
        if (m0_gnt_o || m1_gnt_o) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
            end else begin
                g = gq.pop_front();
                chk("gnt_owner", {30'd0, m1_gnt_o, m0_gnt_o},
                    g.owner ? 32'd2 : 32'd1);
                chk("gnt_mem_req", 32'(mem_req_o), 32'd1);
                chk("gnt_we", 32'(mem_we_o), 32'(g.we));
                chk("gnt_acc", 32'(mem_acc_o), 32'(g.acc));
                chk("gnt_addr", mem_addr_o, g.addr);
                chk("gnt_wdata", mem_wdata_o, g.wdata);
            end
        end
        if (m0_rvalid_o || m1_rvalid_o) begin
            if (rq.size() == 0) begin
                chk("rv_unexpected", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("rv_owner", {30'd0, m1_rvalid_o, m0_rvalid_o},
                    r.owner ? 32'd2 : 32'd1);
                chk("rv_data", r.owner ? m1_rdata_o : m0_rdata_o, r.data);
            end
        end
    end

    initial begin
        logic pat [11];
        pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst_i = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_acc_i = '0; m0_addr_i = '0;
        m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_acc_i = '0; m1_addr_i = '0;
        m1_wdata_i = '0; m1_lock_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

        // Reset state
        step();
        step();
        @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_gnts", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_m0_rdata", m0_rdata_o, 32'd0);
        chk("rst_m1_rdata", m1_rdata_o, 32'd0);
        step();
        rst_i = 1'b0;

        // M0 read, memory answers two cycles after accepting
        step();
        m0_req_i = 1; m0_we_i = 0; m0_acc_i = MEM_ACC_WORD;
        m0_addr_i = 32'h100; m0_wdata_i = '0;
        exp_gnt(0, 0, MEM_ACC_WORD, 32'h100, 32'h0);
        exp_rd(0, 32'hDEADBEEF);
        step();
        m0_req_i = 0; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("t1_gnt_latency", 32'(m0_gnt_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        step();
        mem_gnt_i = 0;
        @(negedge clk_i);
        chk("t1_req_drop", 32'(mem_req_o), 32'd0);
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        chk("t1_rv_early", 32'(m0_rvalid_o), 32'd0);
        step();
        mem_rvalid_i = 0; mem_rdata_i = '0;
        @(negedge clk_i);
        chk("t1_rvalid", 32'(m0_rvalid_o), 32'd1);
        chk("t1_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("t1_m1_rdata", m1_rdata_o, 32'd0);
        step();
        @(negedge clk_i);
        chk("t1_rv_pulse", 32'(m0_rvalid_o), 32'd0);
        chk("t1_rdata_hold", m0_rdata_o, 32'hDEADBEEF);
        chk("t1_idle", 32'(busy_o), 32'd0);

        // Round-robin between two continuous writers, no lock
        do_reset();
        m0_req_i = 1; m0_we_i = 1; m0_acc_i = MEM_ACC_WORD;
        m0_addr_i = 32'h200; m0_wdata_i = 32'hA0A00001;
        m1_req_i = 1; m1_we_i = 1; m1_acc_i = MEM_ACC_WORD;
        m1_addr_i = 32'h300; m1_wdata_i = 32'hB1B10001;
        mem_gnt_i = 1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                exp_gnt(0, 1, MEM_ACC_WORD, 32'h200, 32'hA0A00001);
            else
                exp_gnt(1, 1, MEM_ACC_WORD, 32'h300, 32'hB1B10001);
        end
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 11) begin
                m0_req_i = 0; m1_req_i = 0;
            end
            @(negedge clk_i);
            chk("t2_cadence", 32'(m0_gnt_o | m1_gnt_o), 32'(i % 2));
        end
        step();
        step();
        @(negedge clk_i);
        chk("t2_idle_gnt_ignored", 32'(mem_req_o), 32'd0);
        chk("t2_idle_busy", 32'(busy_o), 32'd0);

        // M1 lock: M0, then four M1 grants, then M0 again
        do_reset();
        m0_req_i = 1; m0_wdata_i = 32'hC0C00002; m0_addr_i = 32'h210;
        m1_req_i = 1; m1_wdata_i = 32'hD1D10002; m1_addr_i = 32'h310;
        mem_gnt_i = 1;
        for (int k = 0; k < 11; k++) begin
            if (pat[k])
                exp_gnt(1, 1, MEM_ACC_WORD, 32'h310, 32'hD1D10002);
            else
                exp_gnt(0, 1, MEM_ACC_WORD, 32'h210, 32'hC0C00002);
        end
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 1) m1_lock_i = 1;
            if (i == 21) begin
                m0_req_i = 0; m1_req_i = 0;
            end
            @(negedge clk_i);
            chk("t3_cadence", 32'(m0_gnt_o | m1_gnt_o), 32'(i % 2));
        end
        m1_lock_i = 0;
        step();

        // Memory stalls five cycles while M0 changes its inputs
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h400;
        m0_wdata_i = 32'h12345678; mem_gnt_i = 0;
        exp_gnt(0, 1, MEM_ACC_WORD, 32'h400, 32'h12345678);
        step();
        m0_req_i = 0; m0_addr_i = 32'h999; m0_wdata_i = 32'hFFFF;
        @(negedge clk_i);
        chk("t4_gnt_first", 32'(m0_gnt_o), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            step();
            @(negedge clk_i);
            chk("t4_gnt_once", 32'(m0_gnt_o), 32'd0);
            chk("t4_req_held", 32'(mem_req_o), 32'd1);
            chk("t4_addr_held", mem_addr_o, 32'h400);
            chk("t4_wdata_held", mem_wdata_o, 32'h12345678);
        end
        step();
        mem_gnt_i = 1;
        @(negedge clk_i);
        chk("t4_req_until_gnt", 32'(mem_req_o), 32'd1);
        step();
        mem_gnt_i = 0;
        @(negedge clk_i);
        chk("t4_done_req", 32'(mem_req_o), 32'd0);
        chk("t4_done_busy", 32'(busy_o), 32'd0);

        // Reset while waiting for read data; late response is dropped
        m1_req_i = 1; m1_we_i = 0; m1_acc_i = MEM_ACC_HALF;
        m1_addr_i = 32'h500; m1_wdata_i = '0;
        exp_gnt(1, 0, MEM_ACC_HALF, 32'h500, 32'h0);
        step();
        m1_req_i = 0; mem_gnt_i = 1;
        step();
        mem_gnt_i = 0; rst_i = 1;
        @(negedge clk_i);
        chk("t5_wait_busy", 32'(busy_o), 32'd1);
        step();
        rst_i = 0;
        @(negedge clk_i);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        step();
        mem_rvalid_i = 0; mem_rdata_i = '0;
        @(negedge clk_i);
        chk("t5_no_rv", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        chk("t5_m1_rdata", m1_rdata_o, 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        m1_req_i = 1; m1_acc_i = MEM_ACC_WORD; m1_addr_i = 32'h600;
        exp_gnt(1, 0, MEM_ACC_WORD, 32'h600, 32'h0);
        exp_rd(1, 32'hCAFEF00D);
        step();
        m1_req_i = 0; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("t5_next_gnt", 32'(m1_gnt_o), 32'd1);
        step();
        mem_gnt_i = 0;
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        step();
        mem_rvalid_i = 0; mem_rdata_i = '0;
        @(negedge clk_i);
        chk("t5_next_rv", 32'(m1_rvalid_o), 32'd1);

        // Stray read response while idle
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        step();
        mem_rvalid_i = 0; mem_rdata_i = '0;
        @(negedge clk_i);
        chk("t6_m1_rdata", m1_rdata_o, 32'hCAFEF00D);
        chk("t6_m0_rdata", m0_rdata_o, 32'd0);
        chk("t6_no_rv", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);

        step();
        step();
        @(negedge clk_i);
        chk("sb_gnt_drained", 32'(gq.size()), 32'd0);
        chk("sb_rd_drained", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
